// File: rtl/result_narrow_queue.sv
// Result narrowing queue: buffers instruction commands, truncates wide FU
// results to the destination EEW and packs them into 64-bit VRF write words.
module result_narrow_queue #(
  parameter int unsigned BufferDepth = 2,
  parameter int unsigned VlWidth     = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [VlWidth-1:0] cmd_vl_i,
  input  logic [1:0]         cmd_eew_i,
  input  logic [1:0]         cmd_conv_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [63:0]        result_i,
  input  logic               result_valid_i,
  output logic               result_ready_o,
  output logic [63:0]        wdata_o,
  output logic [7:0]         wbe_o,
  output logic               wvalid_o,
  input  logic               wready_i,
  output logic               idle_o
);

  localparam int unsigned PtrW = (BufferDepth > 1) ? $clog2(BufferDepth) : 1;
  localparam int unsigned CntW = $clog2(BufferDepth + 1);

  typedef struct packed {
    logic [VlWidth-1:0] vl;
    logic [1:0]         eew;
    logic [1:0]         conv;
  } cmd_t;

  cmd_t               fifo_q [BufferDepth];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               loaded_q, loaded_d;
  logic [VlWidth-1:0] cnt_q, cnt_d;
  logic [2:0]         sel_q, sel_d;
  logic [7:0]         be_q, be_d;
  logic [63:0]        acc_q, acc_d;
  logic               wvalid_q, wvalid_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [7:0]         wbe_q, wbe_d;

  cmd_t               head;
  logic               head_valid, push, pop, beat, word_done;
  logic [3:0]         beat_bytes, beat_elems, take_elems, take_bytes;
  logic [2:0]         sel_nxt;
  logic [VlWidth-1:0] cnt_nxt;
  logic [63:0]        pack_data, acc_nxt;
  logic [7:0]         pack_be, be_nxt;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(BufferDepth - 1)) ? '0 : PtrW'(p + 1'b1);
  endfunction

  assign head        = fifo_q[rd_ptr_q];
  assign head_valid  = (count_q != '0);
  assign cmd_ready_o = (count_q != CntW'(BufferDepth));
  assign push        = cmd_valid_i && cmd_ready_o;

  // Ready only once the head's count is loaded and the output register can take a word
  assign result_ready_o = head_valid && loaded_q && (cnt_q != '0) && (!wvalid_q || wready_i);
  assign beat           = result_valid_i && result_ready_o;

  // Beat geometry and truncating pack of the current result into accumulator lanes
  always_comb begin
    int elem, k, src, dst;
    beat_bytes = 4'd8 >> head.conv;
    beat_elems = beat_bytes >> head.eew;
    take_elems = (cnt_q < VlWidth'(beat_elems)) ? cnt_q[3:0] : beat_elems;
    take_bytes = 4'(take_elems << head.eew);
    pack_data  = '0;
    pack_be    = '0;
    for (int j = 0; j < 8; j++) begin
      elem = j >> head.eew;
      k    = j & ((1 << head.eew) - 1);
      src  = ((elem << (int'(head.conv) + int'(head.eew))) + k) & 7;
      dst  = (int'(sel_q) + j) & 7;
      if (j < int'(take_bytes)) begin
        pack_data[8*dst +: 8] = result_i[8*src +: 8];
        pack_be[dst]          = 1'b1;
      end
    end
    acc_nxt   = acc_q | pack_data;
    be_nxt    = be_q | pack_be;
    sel_nxt   = sel_q + beat_bytes[2:0];
    cnt_nxt   = cnt_q - VlWidth'(take_elems);
    word_done = beat && ((sel_nxt == 3'd0) || (cnt_nxt == '0));
    pop       = (head_valid && loaded_q && (cnt_q == '0)) || (word_done && (cnt_nxt == '0));
  end

  // Next-state for queue control, accumulator and output register
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    loaded_d = loaded_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    be_d     = be_q;
    acc_d    = acc_q;
    wvalid_d = wvalid_q;
    wdata_d  = wdata_q;
    wbe_d    = wbe_q;

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = CntW'(count_q + CntW'(push) - CntW'(pop));

    if (head_valid && !loaded_q) begin
      loaded_d = 1'b1;
      cnt_d    = head.vl;
    end

    if (beat) begin
      cnt_d = cnt_nxt;
      if (word_done) begin
        sel_d = '0;
        be_d  = '0;
        acc_d = '0;
      end else begin
        sel_d = sel_nxt;
        be_d  = be_nxt;
        acc_d = acc_nxt;
      end
    end
    if (pop) loaded_d = 1'b0;

    if (word_done) begin
      wvalid_d = 1'b1;
      wdata_d  = acc_nxt;
      wbe_d    = be_nxt;
    end else if (wready_i) begin
      wvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= '{vl: cmd_vl_i, eew: cmd_eew_i, conv: cmd_conv_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      loaded_q <= 1'b0;
      cnt_q    <= '0;
      sel_q    <= '0;
      be_q     <= '0;
      acc_q    <= '0;
      wvalid_q <= 1'b0;
      wdata_q  <= '0;
      wbe_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      loaded_q <= loaded_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      be_q     <= be_d;
      acc_q    <= acc_d;
      wvalid_q <= wvalid_d;
      wdata_q  <= wdata_d;
      wbe_q    <= wbe_d;
    end
  end

  assign wvalid_o = wvalid_q;
  assign wdata_o  = wdata_q;
  assign wbe_o    = wbe_q;
  assign idle_o   = (count_q == '0) && (be_q == '0) && !wvalid_q;

  // Narrowed source element may not exceed 64 bits
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> ((3'(cmd_conv_i) + 3'(cmd_eew_i)) <= 3'd3));

endmodule
